// File: rtl/lock_reset_ctrl.sv
// Fabric reset controller: filters the CCC LOCK flag, holds off, then releases FABRIC_RESET_N.
// Define LOCK_RST_LOSS_CNT_EN to implement the saturating LOCK_LOSS_CNT register.
module lock_reset_ctrl #(
  parameter int unsigned LOCK_FILTER = 16,
  parameter int unsigned HOLD_CYCLES = 256,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic       GL0,
  input  logic       POWER_ON_RESET_N,
  input  logic       LOCK,
  input  logic       CLR_STATUS,
  output logic       FABRIC_RESET_N,
  output logic       PLL_READY,
  output logic       LOCK_LOST,
  output logic [7:0] LOCK_LOSS_CNT
);

  localparam logic [CNT_WIDTH-1:0] FilterLast = CNT_WIDTH'(LOCK_FILTER - 1);
  localparam logic [CNT_WIDTH-1:0] HoldLast   = CNT_WIDTH'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    StWaitLock,
    StFilter,
    StHold,
    StRun
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 lock_meta_q, lock_sync_q;
  logic                 fabric_rst_n_q, fabric_rst_n_d;
  logic                 pll_ready_q, pll_ready_d;
  logic                 lock_lost_q, lock_lost_d;
  logic                 loss_event;

  // LOCK is asynchronous to GL0; two flops before anything looks at it.
  always_ff @(posedge GL0) begin
    if (!POWER_ON_RESET_N) begin
      lock_meta_q <= 1'b0;
      lock_sync_q <= 1'b0;
    end else begin
      lock_meta_q <= LOCK;
      lock_sync_q <= lock_meta_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    loss_event = 1'b0;
    unique case (state_q)
      StWaitLock: begin
        cnt_d = '0;
        if (lock_sync_q) state_d = StFilter;
      end
      StFilter: begin
        if (!lock_sync_q) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end else if (cnt_q == FilterLast) begin
          state_d = StHold;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StHold: begin
        // Dropping lock during hold-off is a failed bring-up, not a loss.
        if (!lock_sync_q) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end else if (cnt_q == HoldLast) begin
          state_d = StRun;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRun: begin
        cnt_d = '0;
        if (!lock_sync_q) begin
          state_d    = StWaitLock;
          loss_event = 1'b1;
        end
      end
    endcase
  end

  // Outputs come from the next state so they move on the same edge as the state register.
  always_comb begin
    fabric_rst_n_d = (state_d == StRun);
    pll_ready_d    = (state_d == StHold) || (state_d == StRun);
    lock_lost_d    = lock_lost_q;
    if (loss_event) begin
      lock_lost_d = 1'b1;
    end else if (CLR_STATUS) begin
      lock_lost_d = 1'b0;
    end
  end

  always_ff @(posedge GL0) begin
    if (!POWER_ON_RESET_N) begin
      state_q        <= StWaitLock;
      cnt_q          <= '0;
      fabric_rst_n_q <= 1'b0;
      pll_ready_q    <= 1'b0;
      lock_lost_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      fabric_rst_n_q <= fabric_rst_n_d;
      pll_ready_q    <= pll_ready_d;
      lock_lost_q    <= lock_lost_d;
    end
  end

`ifdef LOCK_RST_LOSS_CNT_EN
  logic [7:0] loss_cnt_q, loss_cnt_d;

  // A loss coinciding with a clear restarts the count at one.
  always_comb begin
    loss_cnt_d = loss_cnt_q;
    if (loss_event) begin
      if (CLR_STATUS) begin
        loss_cnt_d = 8'd1;
      end else if (loss_cnt_q != 8'hFF) begin
        loss_cnt_d = loss_cnt_q + 8'd1;
      end
    end else if (CLR_STATUS) begin
      loss_cnt_d = 8'd0;
    end
  end

  always_ff @(posedge GL0) begin
    if (!POWER_ON_RESET_N) begin
      loss_cnt_q <= 8'd0;
    end else begin
      loss_cnt_q <= loss_cnt_d;
    end
  end

  assign LOCK_LOSS_CNT = loss_cnt_q;
`else
  assign LOCK_LOSS_CNT = 8'd0;
`endif

  assign FABRIC_RESET_N = fabric_rst_n_q;
  assign PLL_READY      = pll_ready_q;
  assign LOCK_LOST      = lock_lost_q;

endmodule

// File: tb/tb_lock_reset_ctrl.sv
// Bench for lock_reset_ctrl: a run-length model of the synchronised lock is checked every cycle,
// alongside directed scenarios with literal edge counts and status values.
module tb_lock_reset_ctrl;

  localparam int LF      = 16;
  localparam int HC      = 256;
  localparam int RunRdy  = LF + 1;
  localparam int RunFull = LF + HC + 1;
`ifdef LOCK_RST_LOSS_CNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  logic       gl0 = 1'b0;
  logic       por_n = 1'b0;
  logic       lock = 1'b0;
  logic       clr = 1'b0;
  logic       fabric_rst_n, pll_ready, lock_lost;
  logic [7:0] loss_cnt;

  lock_reset_ctrl #(
    .LOCK_FILTER(LF),
    .HOLD_CYCLES(HC),
    .CNT_WIDTH  (16)
  ) dut (
    .GL0             (gl0),
    .POWER_ON_RESET_N(por_n),
    .LOCK            (lock),
    .CLR_STATUS      (clr),
    .FABRIC_RESET_N  (fabric_rst_n),
    .PLL_READY       (pll_ready),
    .LOCK_LOST       (lock_lost),
    .LOCK_LOSS_CNT   (loss_cnt)
  );

  always #5 gl0 = ~gl0;

  int n_checks = 0;
  int n_pass   = 0;

  function automatic void check_val(input string name, input logic [31:0] act,
                                    input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endfunction

  function automatic int exp_cnt(input int n);
    return CntEn ? n : 0;
  endfunction

  // Model: the synchronised lock is LOCK two edges late; the outputs follow from how many
  // consecutive edges it has been seen high.
  logic m_s1 = 1'b0, m_s2 = 1'b0, m_lost = 1'b0;
  int   m_run = 0, m_cnt = 0;
  wire  m_loss = !m_s2 && (m_run >= RunFull);

  always @(posedge gl0) begin
    if (!por_n) begin
      m_s1 <= 1'b0; m_s2 <= 1'b0; m_run <= 0; m_lost <= 1'b0; m_cnt <= 0;
    end else begin
      m_s1   <= lock;
      m_s2   <= m_s1;
      m_run  <= m_s2 ? ((m_run < RunFull) ? m_run + 1 : m_run) : 0;
      m_lost <= m_loss ? 1'b1 : (clr ? 1'b0 : m_lost);
      if (!CntEn)      m_cnt <= 0;
      else if (m_loss) m_cnt <= clr ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
      else if (clr)    m_cnt <= 0;
    end
  end

  bit cmp_en = 1'b0;
  always @(negedge gl0) begin
    if (cmp_en) begin
      check_val("model fabric_reset_n", 32'(fabric_rst_n), 32'(m_run >= RunFull));
      check_val("model pll_ready", 32'(pll_ready), 32'(m_run >= RunRdy));
      check_val("model lock_lost", 32'(lock_lost), 32'(m_lost));
      check_val("model lock_loss_cnt", 32'(loss_cnt), m_cnt);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge gl0);
  endtask

  // LOCK must have been raised just before the first edge counted here (edge T).
  task automatic measure(input string tag, input int exp_rdy, input int exp_rst);
    int e = 0;
    int e_rdy = -1;
    while (fabric_rst_n !== 1'b1 && e < 2000) begin
      @(posedge gl0);
      #1;
      e++;
      if (e_rdy < 0 && pll_ready === 1'b1) e_rdy = e - 1;
    end
    check_val({tag, " pll_ready rise edge"}, e_rdy, exp_rdy);
    check_val({tag, " fabric_reset_n rise edge"}, e - 1, exp_rst);
    @(negedge gl0);
  endtask

  task automatic wait_pll(input int exp_rdy);
    int e = 0;
    while (pll_ready !== 1'b1 && e < 2000) begin
      @(posedge gl0);
      #1;
      e++;
    end
    check_val("hold pll_ready rise edge", e - 1, exp_rdy);
  endtask

  task automatic do_por();
    por_n = 1'b0;
    tick(2);
    por_n = 1'b1;
    tick(2);
  endtask

  initial begin
    tick(3);
    cmp_en = 1'b1;
    check_val("reset fabric_reset_n", 32'(fabric_rst_n), 0);
    check_val("reset pll_ready", 32'(pll_ready), 0);
    check_val("reset lock_lost", 32'(lock_lost), 0);
    check_val("reset lock_loss_cnt", 32'(loss_cnt), 0);
    por_n = 1'b1;
    tick(4);

    // Clean lock.
    lock = 1'b1;
    measure("clean", 18, 274);
    check_val("clean lock_lost", 32'(lock_lost), 0);

    // Loss in RUN: drop sampled at edge L.
    lock = 1'b0;
    @(posedge gl0);
    @(posedge gl0);
    #1;
    check_val("loss L+1 fabric_reset_n", 32'(fabric_rst_n), 1);
    @(posedge gl0);
    #1;
    check_val("loss L+2 fabric_reset_n", 32'(fabric_rst_n), 0);
    check_val("loss L+2 pll_ready", 32'(pll_ready), 0);
    check_val("loss L+2 lock_lost", 32'(lock_lost), 1);
    check_val("loss L+2 lock_loss_cnt", 32'(loss_cnt), exp_cnt(1));
    @(negedge gl0);
    lock = 1'b1;
    measure("relock", 18, 274);

    // Filter reject after a fresh power-on reset, with a single-cycle glitch first.
    lock = 1'b0;
    do_por();
    lock = 1'b1;
    tick(1);
    lock = 1'b0;
    tick(6);
    check_val("glitch fabric_reset_n", 32'(fabric_rst_n), 0);
    lock = 1'b1;
    tick(10);
    lock = 1'b0;
    tick(5);
    lock = 1'b1;
    measure("filter reject", 18, 274);
    check_val("filter reject lock_loss_cnt", 32'(loss_cnt), 0);

    // Reset mid-hold: POWER_ON_RESET_N sampled low at cycle 100 of HOLD.
    lock = 1'b0;
    tick(4);
    lock = 1'b1;
    wait_pll(18);
    tick(100);
    check_val("mid-hold pll_ready", 32'(pll_ready), 1);
    por_n = 1'b0;
    @(posedge gl0);
    #1;
    check_val("mid-hold reset fabric_reset_n", 32'(fabric_rst_n), 0);
    check_val("mid-hold reset pll_ready", 32'(pll_ready), 0);
    check_val("mid-hold reset lock_lost", 32'(lock_lost), 0);
    check_val("mid-hold reset lock_loss_cnt", 32'(loss_cnt), 0);
    @(negedge gl0);
    por_n = 1'b1;
    measure("after mid-hold reset", 18, 274);

    // Saturation: 257 loss/relock cycles.
    for (int i = 0; i < 257; i++) begin
      lock = 1'b0;
      tick(3);
      lock = 1'b1;
      measure("saturation relock", 18, 274);
    end
    check_val("saturation lock_loss_cnt", 32'(loss_cnt), exp_cnt(255));
    check_val("saturation lock_lost", 32'(lock_lost), 1);

    // CLR_STATUS coincident with a loss: the loss wins.
    lock = 1'b0;
    tick(2);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    check_val("clr+loss lock_lost", 32'(lock_lost), 1);
    check_val("clr+loss lock_loss_cnt", 32'(loss_cnt), exp_cnt(1));
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    check_val("clear lock_lost", 32'(lock_lost), 0);
    check_val("clear lock_loss_cnt", 32'(loss_cnt), 0);
    tick(2);

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
